// File: rtl/sram_fifo_wr_packer.sv
// rtl/sram_fifo_wr_packer.sv - packs per-clock ADC samples into SRAM FIFO words and owns capture length
module sram_fifo_wr_packer #(
    parameter int ADC_MAX_DATA_SIZE = 16,
    parameter int SRAM_WORD_NUM     = 4
) (
    input  logic                                        i_sram_fifo_wr_clk,
    input  logic                                        i_sram_fifo_reset_n,
    input  logic [ADC_MAX_DATA_SIZE-1:0]                i_adc_data_a,
    input  logic [ADC_MAX_DATA_SIZE-1:0]                i_adc_data_b,
    input  logic                                        i_adc_data_valid,
    input  logic [2:0]                                  i_capture_mode,
    input  logic [4:0]                                  i_capture_req_exp,
    input  logic                                        i_capture_start,
    input  logic                                        i_capture_abort,
    output logic [ADC_MAX_DATA_SIZE*SRAM_WORD_NUM-1:0]  o_sram_fifo_wr_data,
    output logic                                        o_sram_fifo_wr_clk_en,
    output logic                                        o_pack_busy,
    output logic                                        o_pack_done,
    output logic [24:0]                                 o_pack_sample_cnt
);

    localparam int W  = ADC_MAX_DATA_SIZE;
    localparam int DW = ADC_MAX_DATA_SIZE * SRAM_WORD_NUM;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                          state_q, state_d;
    logic                            dual_q, dual_d;
    logic [4:0]                      exp_q, exp_d;
    logic [1:0]                      idx_q, idx_d;
    logic [SRAM_WORD_NUM-1:0][W-1:0] lanes_q, lanes_d;
    logic [22:0]                     word_cnt_q, word_cnt_d;
    logic [24:0]                     sample_cnt_q, sample_cnt_d;
    logic [DW-1:0]                   wr_data_q, wr_data_d;
    logic                            wr_clk_en_q, wr_clk_en_d;
    logic                            busy_q, busy_d;
    logic                            done_q, done_d;

    logic [4:0]  exp_clamped;
    logic [4:0]  target_shift;
    logic [23:0] target_words;
    logic [23:0] last_word_idx;
    logic        word_complete;
    logic        last_word;

    // Capture size and word-boundary decode from the latched mode/exp.
    // The word target is one bit wider than the counter so 2^23 (dual, exp=16)
    // is representable; the counter only ever has to reach target-1.
    always_comb begin
        exp_clamped   = (i_capture_req_exp > 5'd16) ? 5'd16 : i_capture_req_exp;
        target_shift  = exp_q + (dual_q ? 5'd7 : 5'd6);
        target_words  = 24'd1 << target_shift;
        last_word_idx = target_words - 24'd1;
        word_complete = dual_q ? idx_q[0] : (idx_q == 2'd3);
        last_word     = ({1'b0, word_cnt_q} == last_word_idx);
    end

    // Next-state, lane packing and counter update; abort overrides everything.
    always_comb begin
        state_d      = state_q;
        dual_d       = dual_q;
        exp_d        = exp_q;
        idx_d        = idx_q;
        lanes_d      = lanes_q;
        word_cnt_d   = word_cnt_q;
        sample_cnt_d = sample_cnt_q;
        wr_data_d    = wr_data_q;
        wr_clk_en_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (i_capture_start) begin
                    state_d      = ST_FILL;
                    dual_d       = (i_capture_mode != 3'b000);
                    exp_d        = exp_clamped;
                    idx_d        = 2'd0;
                    word_cnt_d   = 23'd0;
                    sample_cnt_d = 25'd0;
                end
            end
            ST_FILL: begin
                if (i_adc_data_valid) begin
                    if (dual_q) begin
                        // pair lands in lanes 3/2 first, then 1/0
                        lanes_d[{~idx_q[0], 1'b1}] = i_adc_data_a;
                        lanes_d[{~idx_q[0], 1'b0}] = i_adc_data_b;
                        idx_d = {1'b0, ~idx_q[0]};
                    end else begin
                        lanes_d[2'd3 - idx_q] = i_adc_data_a;
                        idx_d = idx_q + 2'd1;
                    end
                    sample_cnt_d = sample_cnt_q + 25'd1;
                    if (word_complete) begin
                        idx_d       = 2'd0;
                        wr_data_d   = lanes_d;
                        wr_clk_en_d = 1'b1;
                        word_cnt_d  = word_cnt_q + 23'd1;
                        if (last_word) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (i_capture_abort) begin
            state_d      = ST_IDLE;
            idx_d        = 2'd0;
            lanes_d      = lanes_q;
            word_cnt_d   = 23'd0;
            sample_cnt_d = 25'd0;
            wr_data_d    = wr_data_q;
            wr_clk_en_d  = 1'b0;
        end

        busy_d = (state_d == ST_FILL);
        done_d = (state_d == ST_DONE);
    end

    // State and registered outputs; asynchronous reset returns everything to zero.
    always_ff @(posedge i_sram_fifo_wr_clk or negedge i_sram_fifo_reset_n) begin
        if (!i_sram_fifo_reset_n) begin
            state_q      <= ST_IDLE;
            dual_q       <= 1'b0;
            exp_q        <= 5'd0;
            idx_q        <= 2'd0;
            lanes_q      <= '0;
            word_cnt_q   <= 23'd0;
            sample_cnt_q <= 25'd0;
            wr_data_q    <= '0;
            wr_clk_en_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            dual_q       <= dual_d;
            exp_q        <= exp_d;
            idx_q        <= idx_d;
            lanes_q      <= lanes_d;
            word_cnt_q   <= word_cnt_d;
            sample_cnt_q <= sample_cnt_d;
            wr_data_q    <= wr_data_d;
            wr_clk_en_q  <= wr_clk_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign o_sram_fifo_wr_data   = wr_data_q;
    assign o_sram_fifo_wr_clk_en = wr_clk_en_q;
    assign o_pack_busy           = busy_q;
    assign o_pack_done           = done_q;
    assign o_pack_sample_cnt     = sample_cnt_q;

endmodule

// File: tb/tb_sram_fifo_wr_packer.sv
// tb/tb_sram_fifo_wr_packer.sv - randomized self-checking bench for sram_fifo_wr_packer
module tb_sram_fifo_wr_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] adc_a, adc_b;
    logic        adc_valid;
    logic [2:0]  cap_mode;
    logic [4:0]  cap_exp;
    logic        cap_start, cap_abort;
    logic [63:0] wr_data;
    logic        wr_en, busy, done;
    logic [24:0] sample_cnt;

    always #5 clk = ~clk;

    sram_fifo_wr_packer #(.ADC_MAX_DATA_SIZE(16), .SRAM_WORD_NUM(4)) dut (
        .i_sram_fifo_wr_clk    (clk),
        .i_sram_fifo_reset_n   (rst_n),
        .i_adc_data_a          (adc_a),
        .i_adc_data_b          (adc_b),
        .i_adc_data_valid      (adc_valid),
        .i_capture_mode        (cap_mode),
        .i_capture_req_exp     (cap_exp),
        .i_capture_start       (cap_start),
        .i_capture_abort       (cap_abort),
        .o_sram_fifo_wr_data   (wr_data),
        .o_sram_fifo_wr_clk_en (wr_en),
        .o_pack_busy           (busy),
        .o_pack_done           (done),
        .o_pack_sample_cnt     (sample_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Reference model: a capture is a list of accepted samples; every 4 of them
    // (A,A,A,A or A,B,A,B) form a word, first sample in the top lane.
    bit          m_busy, m_done, m_dual, m_strobe;
    int          m_exp;
    longint      m_cnt, m_words;
    logic [15:0] m_q[$];
    logic [63:0] m_data;

    int          obs_strobes;
    bit          obs_first_set;
    logic [63:0] obs_first;

    function automatic void model_reset();
        m_busy = 0; m_done = 0; m_dual = 0; m_strobe = 0; m_exp = 0;
        m_cnt = 0; m_words = 0; m_data = '0;
        m_q.delete();
    endfunction

    function automatic longint model_target();
        return (longint'(1) << (m_exp + 8)) / (m_dual ? 2 : 4);
    endfunction

    function automatic void model_edge(input bit v, input bit s, input bit ab,
                                       input logic [15:0] a, input logic [15:0] b);
        m_strobe = 0;
        if (ab) begin
            m_busy = 0; m_done = 0; m_cnt = 0; m_q.delete();
        end else if (!m_busy && s) begin
            m_busy = 1; m_done = 0;
            m_dual = (cap_mode != 3'd0);
            m_exp  = (int'(cap_exp) > 16) ? 16 : int'(cap_exp);
            m_cnt = 0; m_words = 0; m_q.delete();
        end else if (m_busy && v) begin
            m_q.push_back(a);
            if (m_dual) m_q.push_back(b);
            m_cnt++;
            if (m_q.size() == 4) begin
                m_data = {m_q[0], m_q[1], m_q[2], m_q[3]};
                m_q.delete();
                m_strobe = 1;
                m_words++;
                if (m_words == model_target()) begin
                    m_busy = 0; m_done = 1;
                end
            end
        end
    endfunction

    task automatic check_outputs(input string pfx);
        check({pfx, "_wr_en"},      wr_en,      m_strobe);
        check({pfx, "_busy"},       busy,       m_busy);
        check({pfx, "_done"},       done,       m_done);
        check({pfx, "_sample_cnt"}, sample_cnt, m_cnt);
        check({pfx, "_wr_data"},    wr_data,    m_data);
    endtask

    task automatic step(input bit v, input bit s, input bit ab,
                        input logic [15:0] a, input logic [15:0] b);
        adc_valid = v; cap_start = s; cap_abort = ab; adc_a = a; adc_b = b;
        model_edge(v, s, ab, a, b);
        @(posedge clk);
        #1;
        if (wr_en === 1'b1) begin
            obs_strobes++;
            if (!obs_first_set) begin
                obs_first_set = 1;
                obs_first = wr_data;
            end
        end
        check_outputs("cyc");
    endtask

    // Start a capture and feed it until the model says DONE or the budget runs out.
    // gap: 1 = valid every cycle, N>1 = 1-of-N, 0 = random. pattern 0 = ramp, 1 = random.
    task automatic capture(input bit dual, input int e, input int gap, input int pattern,
                           input bit disturb, input int budget);
        int n;
        bit v, s;
        logic [15:0] a, b;
        cap_mode = dual ? 3'($urandom_range(1, 7)) : 3'd0;
        cap_exp  = 5'(e);
        obs_strobes = 0; obs_first_set = 0;
        step(0, 1, 0, 16'h0, 16'h0);
        n = 0;
        for (int c = 0; c < budget && !m_done; c++) begin
            v = (gap == 0) ? bit'($urandom_range(0, 1)) : ((c % gap) == 0);
            s = disturb && ($urandom_range(0, 15) == 0);
            if (disturb && $urandom_range(0, 7) == 0) begin
                cap_exp  = 5'($urandom_range(0, 31));
                cap_mode = 3'($urandom_range(0, 7));
            end
            if (pattern == 0) begin
                a = 16'(n); b = 16'(16'h8000 + n);
            end else begin
                a = 16'($urandom); b = 16'($urandom);
            end
            step(v, s, 0, a, b);
            if (v) n++;
        end
        check("capture_done_reached", done, 1'b1);
        for (int k = 0; k < 3; k++) step(1, 0, 0, 16'($urandom), 16'($urandom));
    endtask

    initial begin
        rst_n = 1'b0;
        adc_a = '0; adc_b = '0; adc_valid = 0;
        cap_mode = '0; cap_exp = '0; cap_start = 0; cap_abort = 0;
        model_reset();
        obs_strobes = 0; obs_first_set = 0; obs_first = '0;
        #1;
        check_outputs("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 0, 16'h1234, 16'h5678);

        // single, exp=0, ramp
        capture(0, 0, 1, 0, 0, 2000);
        check("t1_strobes", 64'(obs_strobes), 64'd64);
        check("t1_first_word", obs_first, 64'h0000_0001_0002_0003);
        check("t1_sample_cnt", sample_cnt, 25'd256);

        // dual, exp=0, ramp with B offset
        capture(1, 0, 1, 0, 0, 2000);
        check("t2_strobes", 64'(obs_strobes), 64'd128);
        check("t2_first_word", obs_first, 64'h0000_8000_0001_8001);

        // single, valid 1-of-3
        capture(0, 0, 3, 0, 0, 3000);
        check("t3_strobes", 64'(obs_strobes), 64'd64);
        check("t3_first_word", obs_first, 64'h0000_0001_0002_0003);

        // abort after 6 valids, then restart fresh
        cap_mode = 3'd0; cap_exp = 5'd0;
        obs_strobes = 0; obs_first_set = 0;
        step(0, 1, 0, 16'h0, 16'h0);
        for (int n = 0; n < 6; n++) step(1, 0, 0, 16'(n), 16'h0);
        step(1, 1, 1, 16'h0bad, 16'h0bad);
        check("t4_strobes", 64'(obs_strobes), 64'd1);
        check("t4_busy", busy, 1'b0);
        check("t4_done", done, 1'b0);
        check("t4_sample_cnt", sample_cnt, 25'd0);
        capture(0, 0, 1, 0, 0, 2000);
        check("t4_restart_first_word", obs_first, 64'h0000_0001_0002_0003);

        // start pulses and exp/mode changes during FILL are ignored
        capture(0, 1, 1, 1, 1, 3000);
        check("t5_strobes", 64'(obs_strobes), 64'd128);

        // random captures
        for (int r = 0; r < 4; r++) begin
            bit d;
            int e;
            d = bit'($urandom_range(0, 1));
            e = $urandom_range(0, 1);
            capture(d, e, 0, 1, 1, 8000);
            check("rand_strobes", 64'(obs_strobes), 64'(model_target()));
        end

        // async reset after 10 words, then clamped exp=31 keeps running
        cap_mode = 3'd0; cap_exp = 5'd31;
        obs_strobes = 0; obs_first_set = 0;
        step(0, 1, 0, 16'h0, 16'h0);
        for (int c = 0; c < 200 && obs_strobes < 10; c++) step(1, 0, 0, 16'($urandom), 16'h0);
        check("t6_words_before_reset", 64'(obs_strobes), 64'd10);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("t6_async_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1, 0, 0, 16'h1, 16'h2);
        check("t6_no_strobe_after_release", wr_en, 1'b0);
        cap_exp = 5'd31;
        obs_strobes = 0; obs_first_set = 0;
        step(0, 1, 0, 16'h0, 16'h0);
        for (int c = 0; c < 3000; c++) step(1, 0, 0, 16'($urandom), 16'h0);
        check("t6_clamp_busy", busy, 1'b1);
        check("t6_clamp_strobes", 64'(obs_strobes), 64'd750);
        check("t6_clamp_cnt", sample_cnt, 25'd3000);
        step(0, 0, 1, 16'h0, 16'h0);
        check("t6_abort_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
